// File: rtl/div16by8_seq.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Valid/ready handshakes on both sides; outputs come straight from registers.
module div16by8_seq #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e state_q, state_d;

  // Partial remainder stays below D after every step, so its top bit
  // is always zero; the extra bit only exists in the trial value t.
  logic [VW-1:0] r_q, r_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;

  logic [VW:0] t;
  logic [VW:0] diff;
  logic        ge;

  always_comb begin
    t    = {r_q, q_q[DW-1]};
    diff = t - {1'b0, d_q};
    ge   = (t >= {1'b0, d_q});
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d   = dividend;
          d_d   = divisor;
          r_d   = '0;
          cnt_d = '0;
          if (divisor == '0) begin
            dbz_d   = 1'b1;
            q_d     = '1;
            state_d = DONE;
          end else begin
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        r_d   = ge ? diff[VW-1:0] : t[VW-1:0];
        q_d   = {q_q[DW-2:0], ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div16by8_seq.sv
// Self-checking bench for div16by8_seq: directed cases plus
// randomised operands checked against plain integer division.
module tb_div16by8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  div16by8_seq #(.DW(16), .VW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic accept(input logic [15:0] a, input logic [7:0] b);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
    chk("busy_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       input int stall);
    int lat;
    logic [15:0] eq;
    logic [7:0]  er;
    logic [31:0] q32;
    if (b == 8'd0) begin
      eq = 16'hFFFF;
      er = 8'd0;
    end else begin
      eq = a / b;
      er = a % b;
    end
    out_ready = 1'b0;
    accept(a, b);
    wait_out(lat);
    chk("latency", 32'(lat), (b == 8'd0) ? 32'd0 : 32'd16);
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_by_zero", 32'(div_by_zero), 32'(b == 8'd0));
    if (b != 8'd0) begin
      q32 = 32'(quotient);
      chk("identity", q32 * 32'(b) + 32'(remainder), 32'(a));
      chk("rem_lt_div", 32'(remainder < b), 32'd1);
      chk("mul8_xchk", 32'(quotient[7:0]) * 32'(b),
          32'(a) - 32'(remainder) - ((32'(quotient[15:8]) * 32'(b)) << 8));
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_q", 32'(quotient), 32'(eq));
      chk("stall_r", 32'(remainder), 32'(er));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] hq;
    logic [7:0]  hr;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    do_op(16'hFFFF, 8'hFF, 0);
    do_op(16'd1000, 8'd7, 2);
    do_op(16'd5, 8'd9, 1);
    do_op(16'd12345, 8'd1, 0);
    do_op(16'h1234, 8'h00, 3);
    do_op(16'd100, 8'd10, 0);

    // Backpressure with a new operand waiting the whole time.
    accept(16'd50000, 8'd250);
    wait_out(lat);
    chk("bp_latency", 32'(lat), 32'd16);
    hq = quotient;
    hr = remainder;
    chk("bp_q", 32'(hq), 32'd200);
    chk("bp_r", 32'(hr), 32'd0);
    in_valid = 1'b1;
    dividend = 16'd777;
    divisor  = 8'd10;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_q", 32'(quotient), 32'd200);
      chk("bp_hold_r", 32'(remainder), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_hs_valid", 32'(out_valid), 32'd0);
    chk("bp_hs_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_accepted", 32'(in_ready), 32'd0);
    wait_out(lat);
    chk("bp2_latency", 32'(lat), 32'd16);
    chk("bp2_q", 32'(quotient), 32'd77);
    chk("bp2_r", 32'(remainder), 32'd7);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a division.
    accept(16'hFFFF, 8'd3);
    repeat (8) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_q", 32'(quotient), 32'd0);
    chk("mid_rst_r", 32'(remainder), 32'd0);
    chk("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    do_op(16'd200, 8'd3, 0);
    chk("post_rst_q", 32'(quotient), 32'd66);
    chk("post_rst_r", 32'(remainder), 32'd2);

    for (int k = 0; k < 2000; k++) begin
      a = 16'($urandom);
      if ($urandom_range(3) == 0) a = 16'($urandom_range(255));
      b = 8'($urandom_range(255, 1));
      do_op(a, b, int'($urandom_range(3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
